// File: rtl/spart_tx_arbiter.sv
// Round-robin arbiter sharing one SPART transmitter among NUM_REQ byte sources.
// Optional macro SPART_ARB_BURST_EN lets a winner send up to MAX_BURST bytes per grant.
module spart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 16
`ifdef SPART_ARB_BURST_EN
    ,
    parameter int unsigned MAX_BURST = 4
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   data_in,
    input  logic                   tbr,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int unsigned PW    = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state, state_d;
    logic [PW-1:0]      ptr, ptr_d;
    logic [PW-1:0]      win, win_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               tbr_prev;
    logic               tbr_rise;
    logic               arb_found;
    logic [PW-1:0]      arb_win;
    logic               tx_start_d;
    logic [7:0]         tx_data_d;
    logic [NUM_REQ-1:0] grant_d;
    logic               busy_d;
    logic               timeout_err_d;
`ifdef SPART_ARB_BURST_EN
    logic [3:0]         burst, burst_d;
`endif

    // Index v+k modulo NUM_REQ (k < NUM_REQ), so the pointer wraps at NUM_REQ, not 2**PW.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v, input int k);
        logic [PW:0] s;
        s = {1'b0, v} + (PW+1)'(k);
        if (s >= (PW+1)'(NUM_REQ)) s = s - (PW+1)'(NUM_REQ);
        return s[PW-1:0];
    endfunction

    assign tbr_rise = !tbr_prev && tbr;

    // First requester at or after ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = ptr;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!arb_found && req[wrap_inc(ptr, i)]) begin
                arb_found = 1'b1;
                arb_win   = wrap_inc(ptr, i);
            end
        end
    end

    always_comb begin
        state_d       = state;
        ptr_d         = ptr;
        win_d         = win;
        cnt_d         = cnt;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data;
        grant_d       = '0;
        timeout_err_d = 1'b0;
`ifdef SPART_ARB_BURST_EN
        burst_d       = burst;
`endif
        case (state)
            IDLE: begin
                if (tbr && arb_found) begin
                    state_d    = ISSUE;
                    win_d      = arb_win;
                    tx_start_d = 1'b1;
                    grant_d    = NUM_REQ'(1) << arb_win;
                    tx_data_d  = data_in[{arb_win, 3'b000} +: 8];
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                cnt_d   = '0;
            end
            WAIT_BUSY: begin
                if (!tbr) begin
                    state_d = WAIT_DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    // Byte is lost; the grant was already given, so move on.
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                    ptr_d         = wrap_inc(win, 1);
`ifdef SPART_ARB_BURST_EN
                    burst_d       = '0;
`endif
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (tbr_rise) begin
`ifdef SPART_ARB_BURST_EN
                    if (req[win] && (burst < 4'(MAX_BURST - 1))) begin
                        state_d    = ISSUE;
                        burst_d    = burst + 4'd1;
                        tx_start_d = 1'b1;
                        grant_d    = NUM_REQ'(1) << win;
                        tx_data_d  = data_in[{win, 3'b000} +: 8];
                    end else begin
                        state_d = IDLE;
                        ptr_d   = wrap_inc(win, 1);
                        burst_d = '0;
                    end
`else
                    state_d = IDLE;
                    ptr_d   = wrap_inc(win, 1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            win         <= '0;
            cnt         <= '0;
            tbr_prev    <= 1'b1;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
`ifdef SPART_ARB_BURST_EN
            burst       <= '0;
`endif
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            win         <= win_d;
            cnt         <= cnt_d;
            tbr_prev    <= tbr;
            tx_start    <= tx_start_d;
            tx_data     <= tx_data_d;
            grant       <= grant_d;
            busy        <= busy_d;
            timeout_err <= timeout_err_d;
`ifdef SPART_ARB_BURST_EN
            burst       <= burst_d;
`endif
        end
    end

endmodule
